// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array result path.
// Holds the default datapath widths, the result-writer FSM state encoding and
// a small helper for sizing lane index buses.
package systolic_pkg;

  localparam int unsigned ACC_W_DEF   = 16;
  localparam int unsigned N_MACS_DEF  = 4;
  localparam int unsigned ADDR_W_DEF  = 8;
  // Number of discrete accumulator ports on the writer (acc_in_0 .. acc_in_3).
  localparam int unsigned N_ACC_PORTS = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StDrain = 2'd2
  } wr_state_e;

  // Width of a binary lane index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_lane_sel.sv
// Fixed-priority lane selector for the result writer.
// Ports:
//   pending_i  per-lane pending flags
//   grant_o    one-hot grant of the lowest-index pending lane (zero if none)
//   idx_o      binary index of the granted lane (zero if none)
//   any_o      at least one lane pending
module result_lane_sel
  import systolic_pkg::*;
#(
  parameter int unsigned N_MACS = N_MACS_DEF,
  parameter int unsigned IDX_W  = idx_width(N_MACS)
) (
  input  logic [N_MACS-1:0] pending_i,
  output logic [N_MACS-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  // Scan from the top down so the lowest pending index is the last write.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int i = int'(N_MACS) - 1; i >= 0; i--) begin
      if (pending_i[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
  end

  assign any_o = |pending_i;

endmodule

// File: rtl/result_mem_wr.sv
// Result memory writer: collects MAC lane accumulator results into per-lane
// holding registers and streams them to the result memory over a
// valid/ready write port at consecutive addresses starting at a base.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  one-cycle pulse arming a run (accepted in idle only)
//   base_addr_i, word_cnt_i  first address and word count, sampled on start
//   acc_in_0_i..acc_in_3_i   lane accumulator values (signed)
//   valid_in_i               per-lane capture strobes
//   wr_valid_o, wr_ready_i   write handshake to result memory
//   wr_addr_o, wr_data_o     write address / data
//   busy_o                   run in progress (armed or draining)
//   done_o                   one-cycle pulse after the final write
//   err_overflow_o           sticky: a lane result was dropped
//
// Build option: define RESULT_RELU_EN to clamp negative captured values to
// zero before storage.
//
// N_MACS must not exceed the four accumulator ports; extra lanes read zero.
module result_mem_wr
  import systolic_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned N_MACS = N_MACS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        base_addr_i,
  input  logic [ADDR_W-1:0]        word_cnt_i,
  input  logic signed [ACC_W-1:0]  acc_in_0_i,
  input  logic signed [ACC_W-1:0]  acc_in_1_i,
  input  logic signed [ACC_W-1:0]  acc_in_2_i,
  input  logic signed [ACC_W-1:0]  acc_in_3_i,
  input  logic [N_MACS-1:0]        valid_in_i,
  output logic                     wr_valid_o,
  input  logic                     wr_ready_i,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [ACC_W-1:0]         wr_data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_overflow_o
);

  localparam int unsigned IDX_W = idx_width(N_MACS);

  wr_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [N_MACS-1:0]  pending_q, pending_d;
  logic [ACC_W-1:0]   hold_q [N_MACS];
  logic [ACC_W-1:0]   hold_d [N_MACS];
  logic               err_q, err_d;
  logic               done_q, done_d;
  // While a write is stalled the presented lane is frozen, so a capture into
  // a lower-index lane cannot change wr_addr/wr_data mid-handshake.
  logic               lock_q, lock_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  logic signed [ACC_W-1:0] acc_port [N_ACC_PORTS];
  logic [ACC_W-1:0]        cap_val  [N_MACS];
  logic [N_MACS-1:0]       arb_grant, sel_grant;
  logic [IDX_W-1:0]        arb_idx, sel_idx;
  logic                    any_pending;
  logic                    accept;
  logic [ADDR_W-1:0]       wr_cnt_inc;

  assign acc_port[0] = acc_in_0_i;
  assign acc_port[1] = acc_in_1_i;
  assign acc_port[2] = acc_in_2_i;
  assign acc_port[3] = acc_in_3_i;

  // Value stored into each lane's holding register on capture.
  always_comb begin
    for (int i = 0; i < int'(N_MACS); i++) begin
      cap_val[i] = '0;
      if (i < int'(N_ACC_PORTS)) begin
        cap_val[i] = acc_port[i % int'(N_ACC_PORTS)];
`ifdef RESULT_RELU_EN
        if (acc_port[i % int'(N_ACC_PORTS)][ACC_W-1]) begin
          cap_val[i] = '0;
        end
`endif
      end
    end
  end

  result_lane_sel #(
    .N_MACS (N_MACS),
    .IDX_W  (IDX_W)
  ) u_lane_sel (
    .pending_i (pending_q),
    .grant_o   (arb_grant),
    .idx_o     (arb_idx),
    .any_o     (any_pending)
  );

  always_comb begin
    sel_grant = arb_grant;
    sel_idx   = arb_idx;
    if (lock_q) begin
      sel_grant          = '0;
      sel_grant[lock_idx_q] = 1'b1;
      sel_idx            = lock_idx_q;
    end
  end

  assign accept     = any_pending & wr_ready_i;
  assign wr_cnt_inc = wr_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    wr_cnt_d   = wr_cnt_q;
    pending_d  = pending_q;
    hold_d     = hold_q;
    err_d      = err_q;
    done_d     = 1'b0;
    lock_d     = 1'b0;
    lock_idx_d = lock_idx_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          base_d    = base_addr_i;
          cnt_d     = word_cnt_i;
          wr_cnt_d  = '0;
          pending_d = '0;
          err_d     = 1'b0;
          if (word_cnt_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StArmed;
          end
        end
      end

      StArmed, StDrain: begin
        if (accept) begin
          pending_d = pending_q & ~sel_grant;
          wr_cnt_d  = wr_cnt_inc;
          state_d   = StDrain;
        end

        // A lane being written this cycle frees its slot, so a same-cycle
        // capture is kept; otherwise a busy slot drops the new value.
        for (int i = 0; i < int'(N_MACS); i++) begin
          if (valid_in_i[i]) begin
            if (!pending_q[i] || (accept && sel_grant[i])) begin
              hold_d[i]    = cap_val[i];
              pending_d[i] = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        if (any_pending && !wr_ready_i) begin
          lock_d     = 1'b1;
          lock_idx_d = sel_idx;
        end

        // Final word: leftovers are discarded and the run closes.
        if (accept && (wr_cnt_inc == cnt_q)) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          pending_d = '0;
        end
      end

      default: begin
        state_d   = StIdle;
        pending_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      base_q     <= '0;
      cnt_q      <= '0;
      wr_cnt_q   <= '0;
      pending_q  <= '0;
      for (int i = 0; i < int'(N_MACS); i++) begin
        hold_q[i] <= '0;
      end
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      pending_q  <= pending_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      done_q     <= done_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign wr_valid_o     = any_pending;
  assign wr_addr_o      = base_q + wr_cnt_q;
  assign wr_data_o      = any_pending ? hold_q[sel_idx] : '0;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign err_overflow_o = err_q;

endmodule

// File: tb/tb_result_mem_wr.sv
// Directed self-checking bench for result_mem_wr (default parameters).
// Honours RESULT_RELU_EN when computing the expected value of a negative word.
module tb_result_mem_wr;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic [7:0]         base_addr_i;
  logic [7:0]         word_cnt_i;
  logic signed [15:0] acc_in_0_i, acc_in_1_i, acc_in_2_i, acc_in_3_i;
  logic [3:0]         valid_in_i;
  logic               wr_valid_o;
  logic               wr_ready_i;
  logic [7:0]         wr_addr_o;
  logic [15:0]        wr_data_o;
  logic               busy_o;
  logic               done_o;
  logic               err_overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  result_mem_wr dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .word_cnt_i     (word_cnt_i),
    .acc_in_0_i     (acc_in_0_i),
    .acc_in_1_i     (acc_in_1_i),
    .acc_in_2_i     (acc_in_2_i),
    .acc_in_3_i     (acc_in_3_i),
    .valid_in_i     (valid_in_i),
    .wr_valid_o     (wr_valid_o),
    .wr_ready_i     (wr_ready_i),
    .wr_addr_o      (wr_addr_o),
    .wr_data_o      (wr_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_overflow_o (err_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic [7:0] a, input logic [15:0] d);
    check({tag, ".valid"}, 32'(wr_valid_o), 32'd1);
    check({tag, ".addr"}, 32'(wr_addr_o), 32'(a));
    check({tag, ".data"}, 32'(wr_data_o), 32'(d));
  endtask

  task automatic do_start(input logic [7:0] b, input logic [7:0] c);
    base_addr_i = b;
    word_cnt_i  = c;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic set_acc(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3);
    acc_in_0_i = a0;
    acc_in_1_i = a1;
    acc_in_2_i = a2;
    acc_in_3_i = a3;
  endtask

  logic [15:0] relu_exp;

  initial begin
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    word_cnt_i  = '0;
    set_acc(0, 0, 0, 0);
    valid_in_i  = '0;
    wr_ready_i  = 1'b0;
    repeat (2) tick();
    check("rst.wr_valid", 32'(wr_valid_o), 0);
    check("rst.wr_addr", 32'(wr_addr_o), 0);
    check("rst.busy", 32'(busy_o), 0);
    check("rst.done", 32'(done_o), 0);
    check("rst.err", 32'(err_overflow_o), 0);
    rst_ni = 1'b1;

    // Burst of four lanes, memory always ready.
    do_start(8'h10, 8'd4);
    check("t1.busy", 32'(busy_o), 1);
    check("t1.novalid", 32'(wr_valid_o), 0);
    set_acc(1, 2, 3, 4);
    valid_in_i = 4'b1111;
    wr_ready_i = 1'b1;
    tick();
    valid_in_i = '0;
    expect_wr("t1.w0", 8'h10, 16'd1);
    tick();
    expect_wr("t1.w1", 8'h11, 16'd2);
    tick();
    expect_wr("t1.w2", 8'h12, 16'd3);
    tick();
    expect_wr("t1.w3", 8'h13, 16'd4);
    check("t1.done_early", 32'(done_o), 0);
    tick();
    check("t1.done", 32'(done_o), 1);
    check("t1.idle_valid", 32'(wr_valid_o), 0);
    check("t1.idle_busy", 32'(busy_o), 0);
    tick();
    check("t1.done_pulse", 32'(done_o), 0);

    // Staggered captures with a three-cycle stall.
    wr_ready_i = 1'b0;
    do_start(8'h20, 8'd4);
    set_acc(16'h11, 16'h22, 16'h33, 16'h44);
    valid_in_i = 4'b0001;
    tick();
    expect_wr("t2.first", 8'h20, 16'h11);
    valid_in_i = 4'b0010;
    tick();
    expect_wr("t2.stall1", 8'h20, 16'h11);
    valid_in_i = 4'b0100;
    tick();
    expect_wr("t2.stall2", 8'h20, 16'h11);
    valid_in_i = 4'b1000;
    tick();
    expect_wr("t2.stall3", 8'h20, 16'h11);
    valid_in_i = '0;
    wr_ready_i = 1'b1;
    tick();
    expect_wr("t2.w1", 8'h21, 16'h22);
    tick();
    expect_wr("t2.w2", 8'h22, 16'h33);
    tick();
    expect_wr("t2.w3", 8'h23, 16'h44);
    tick();
    check("t2.done", 32'(done_o), 1);
    check("t2.err", 32'(err_overflow_o), 0);

    // Overflow on lane 2: first value kept, second dropped.
    wr_ready_i = 1'b0;
    do_start(8'h30, 8'd2);
    set_acc(16'h9, 0, 16'd5, 0);
    valid_in_i = 4'b0100;
    tick();
    check("t3.err_pre", 32'(err_overflow_o), 0);
    set_acc(16'h9, 0, 16'd6, 0);
    tick();
    valid_in_i = '0;
    check("t3.err", 32'(err_overflow_o), 1);
    expect_wr("t3.held", 8'h30, 16'd5);
    wr_ready_i = 1'b1;
    tick();
    check("t3.drained", 32'(wr_valid_o), 0);
    check("t3.busy", 32'(busy_o), 1);
    valid_in_i = 4'b0001;
    tick();
    valid_in_i = '0;
    expect_wr("t3.w1", 8'h31, 16'h9);
    tick();
    check("t3.done", 32'(done_o), 1);
    check("t3.err_sticky", 32'(err_overflow_o), 1);

    // Address wrap; the start also clears the sticky error.
    do_start(8'hFE, 8'd3);
    check("t4.err_clr", 32'(err_overflow_o), 0);
    set_acc(7, 8, 9, 0);
    valid_in_i = 4'b0111;
    tick();
    valid_in_i = '0;
    expect_wr("t4.w0", 8'hFE, 16'd7);
    tick();
    expect_wr("t4.w1", 8'hFF, 16'd8);
    tick();
    expect_wr("t4.w2", 8'h00, 16'd9);
    tick();
    check("t4.done", 32'(done_o), 1);

    // Zero-length run, idle strobes ignored, start while busy ignored.
    do_start(8'h50, 8'd0);
    check("t5.done", 32'(done_o), 1);
    check("t5.busy", 32'(busy_o), 0);
    check("t5.novalid", 32'(wr_valid_o), 0);
    set_acc(1, 2, 3, 4);
    valid_in_i = 4'b1111;
    tick();
    valid_in_i = '0;
    check("t5.done_pulse", 32'(done_o), 0);
    tick();
    check("t5.idle_ignored", 32'(wr_valid_o), 0);
    do_start(8'h60, 8'd2);
    check("t5.busy2", 32'(busy_o), 1);
    do_start(8'h70, 8'd5);
    valid_in_i = 4'b0011;
    tick();
    valid_in_i = '0;
    expect_wr("t5.w0", 8'h60, 16'd1);
    tick();
    expect_wr("t5.w1", 8'h61, 16'd2);
    tick();
    check("t5.done2", 32'(done_o), 1);
    check("t5.idle2", 32'(busy_o), 0);

    // Reset mid-drain with two lanes still pending.
    do_start(8'h80, 8'd4);
    set_acc(16'hA, 16'hB, 16'hC, 0);
    valid_in_i = 4'b0111;
    tick();
    valid_in_i = '0;
    expect_wr("t6.w0", 8'h80, 16'hA);
    tick();
    expect_wr("t6.w1", 8'h81, 16'hB);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6.rst_valid", 32'(wr_valid_o), 0);
    check("t6.rst_addr", 32'(wr_addr_o), 0);
    check("t6.rst_data", 32'(wr_data_o), 0);
    check("t6.rst_busy", 32'(busy_o), 0);
    check("t6.rst_done", 32'(done_o), 0);
    check("t6.rst_err", 32'(err_overflow_o), 0);
    repeat (2) tick();
    check("t6.rst_hold", 32'(wr_valid_o), 0);
    rst_ni = 1'b1;
    do_start(8'h90, 8'd1);
    check("t6.restart", 32'(busy_o), 1);

    // Negative accumulator, clamped only when the ReLU option is built in.
`ifdef RESULT_RELU_EN
    relu_exp = 16'h0000;
`else
    relu_exp = 16'hFFF9;
`endif
    set_acc(-16'sd7, 0, 0, 0);
    valid_in_i = 4'b0001;
    tick();
    valid_in_i = '0;
    expect_wr("t7.neg", 8'h90, relu_exp);
    tick();
    check("t7.done", 32'(done_o), 1);
    check("t7.novalid", 32'(wr_valid_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_mem_wr.md
RESULT_MEM_WR -- requirements
Module: result_mem_wr

Interface
REQ-001 Parameter ACC_W, default 16: accumulator/result word width.
REQ-002 Parameter N_MACS, default 4: number of MAC lanes captured.
REQ-003 Parameter ADDR_W, default 8: result memory address width.
REQ-004 clk  input  1: single clock; all state on rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-low.
REQ-006 start  input  1: one-cycle pulse; arms a result-collection run.
REQ-007 base_addr  input  ADDR_W: first write address, sampled on accepted start.
REQ-008 word_cnt  input  ADDR_W: number of words to write this run, sampled on accepted start.
REQ-009 acc_in_0..acc_in_3  input  ACC_W signed each: MAC array accumulator outputs.
REQ-010 valid_in  input  N_MACS: per-lane result-valid strobe, bit i qualifies acc_in_i.
REQ-011 wr_valid  output  1: write request to result memory.
REQ-012 wr_ready  input  1: memory accepts write when wr_valid && wr_ready.
REQ-013 wr_addr  output  ADDR_W; wr_data  output  ACC_W: write address and data.
REQ-014 busy  output  1: high in ARMED and DRAIN states.
REQ-015 done  output  1: one-cycle pulse when the run completes.
REQ-016 err_overflow  output  1: sticky, a lane result was dropped.

Function
REQ-017 The FSM SHALL have states IDLE, ARMED, DRAIN; start SHALL be accepted only in IDLE and ignored otherwise.
REQ-018 Accepted start SHALL latch base_addr and word_cnt, clear written-count, pending flags and err_overflow, and enter ARMED next cycle; word_cnt==0 SHALL instead pulse done next cycle and stay IDLE with no writes.
REQ-019 In ARMED/DRAIN, each set valid_in[i] SHALL capture acc_in_i into lane-i holding register and set pending[i]; valid_in SHALL be ignored in IDLE.
REQ-020 If valid_in[i] is set while pending[i] is set and that lane is not being accepted this cycle, the new value SHALL be dropped and err_overflow set.
REQ-021 Capture into a lane accepted by the memory in the same cycle SHALL be kept (pending stays set with the new value).
REQ-022 wr_valid SHALL assert whenever any pending flag is set, presenting the lowest-index pending lane; wr_addr/wr_data SHALL remain stable while wr_valid && !wr_ready.
REQ-023 wr_addr SHALL equal base_addr + written-count, modulo 2^ADDR_W (wrap-around allowed).
REQ-024 Latency: a value captured at edge n SHALL be presentable on wr_valid at cycle n+1 at the earliest.
REQ-025 ARMED SHALL move to DRAIN on the first accepted write; on the write making written-count equal word_cnt, the FSM SHALL return to IDLE, pulse done the following cycle, and discard remaining pending flags.
REQ-026 err_overflow SHALL hold until the next accepted start or reset.

Reset
REQ-027 Asserting rst (low) at any time, including mid-run, SHALL immediately force IDLE, pending=0, counters=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, err_overflow=0.
REQ-028 After rst deasserts, the block SHALL be ready to accept start on the first clock edge.

Configuration
REQ-029 Macro RESULT_RELU_EN: when defined, a captured value with sign bit set SHALL be stored as 0; when undefined, values SHALL be stored unmodified.

Structure
REQ-030 Shared package systolic_pkg SHALL hold ACC_W/N_MACS/ADDR_W defaults and the FSM state encoding (IDLE=0, ARMED=1, DRAIN=2).
REQ-031 Lane selection SHALL be a sub-module result_lane_sel: N_MACS-bit pending in, one-hot grant and binary index out, lowest index wins.

Verification
REQ-032 start, base=0x10, cnt=4; valid_in=4'b1111 with acc=1,2,3,4; wr_ready=1 -> writes (0x10,1),(0x11,2),(0x12,3),(0x13,4) on consecutive cycles, done one cycle later.
REQ-033 Staggered valid_in 0001,0010,0100,1000 on consecutive cycles, wr_ready=0 for 3 cycles then 1 -> data order lane0..3, wr_addr/wr_data stable while stalled.
REQ-034 wr_ready=0, valid_in[2] twice (values 5 then 6) -> err_overflow=1, value 5 written, 6 dropped; next start clears err_overflow.
REQ-035 base=0xFE, cnt=3 -> addresses 0xFE, 0xFF, 0x00.
REQ-036 start with cnt=0 -> done next cycle, wr_valid never asserts; start while busy -> ignored, latched base unchanged.
REQ-037 rst low mid-DRAIN with two lanes pending -> all outputs zero same cycle, no further writes; with RESULT_RELU_EN, acc=-7 -> wr_data=0.
